pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 4, register-specifier width.
REQ-002 SHALL have parameter DRAIN_CYC, default 3, cycles for HLT to travel from ID to retirement.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports id_rs, id_rt  input  REG_W  source registers of the instruction in ID.
REQ-006 SHALL have ports id_use_rs, id_use_rt  input  1  ID instruction reads rs / rt.
REQ-007 SHALL have ports ex_memread  input  1, ex_rd  input  REG_W  EX stage holds a load writing ex_rd.
REQ-008 SHALL have port ex_br_taken  input  1  EX resolved a taken branch or jump.
REQ-009 SHALL have ports imiss, dmiss  input  1  instruction / data memory not ready; level, held until done.
REQ-010 SHALL have port id_halt  input  1  ID holds HLT.
REQ-011 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1  pipeline-register write enables.
REQ-012 SHALL have ports ifid_flush, idex_flush, memwb_flush  output  1  synchronous bubble insert into that register.
REQ-013 SHALL have ports halted  output  1, stall_cnt  output  16  halt status and stall performance counter.

Function
REQ-014 SHALL compute all enables/flushes combinationally from inputs and current state, effective at the next clk edge (zero-cycle decision latency).
REQ-015 SHALL define flush as dominating enable at the controlled register: a flushed register loads its bubble even when its enable is 0.
REQ-016 SHALL have FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-017 SHALL apply, in RUN and DRAIN, the highest-priority active event, strictly in this order: dmiss, ex_br_taken, load-use, imiss, id_halt; with no event, all five enables 1, all flushes 0.
REQ-018 SHALL on dmiss: pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, memwb_flush=1; ex_br_taken and load-use are ignored that cycle.
REQ-019 SHALL on ex_br_taken: all enables 1, ifid_flush=1, idex_flush=1.
REQ-020 SHALL detect load-use as ex_memread & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)); register 0 never hazards.
REQ-021 SHALL on load-use: pc_en=0, ifid_en=0, idex_flush=1, remaining enables 1.
REQ-022 SHALL on imiss: pc_en=0, ifid_flush=1, remaining enables 1.
REQ-023 SHALL in RUN on id_halt (no higher event): pc_en=0, ifid_en=0, others 1; load drain counter with DRAIN_CYC; go to DRAIN.
REQ-024 SHALL in DRAIN: hold pc_en=0, ifid_en=0; decrement counter on each cycle without dmiss; hold it while dmiss is active.
REQ-025 SHALL in DRAIN on ex_br_taken (HLT is younger and killed): apply REQ-019, clear counter, return to RUN.
REQ-026 SHALL move DRAIN->HALTED on the edge where the counter goes 1->0.
REQ-027 SHALL in HALTED: all enables 0, all flushes 0, halted=1; leave only by reset.
REQ-028 SHALL increment stall_cnt on every edge where pc_en=0 and state!=HALTED; saturate at 16'hFFFF.

Reset
REQ-029 SHALL while rst=1 force state RUN, drain counter 0, stall_cnt 0, halted 0, all enables 0, all flushes 0, regardless of clk.
REQ-030 SHALL on rst assertion mid-DRAIN or mid-stall abandon that operation immediately; first cycle after release behaves as RUN with no history.

Verification
REQ-031 SHALL cover load-use: ex_memread=1, ex_rd=3, id_rs=3, id_use_rs=1 -> pc_en=0, ifid_en=0, idex_flush=1; ex_rd=0 same stimulus -> no stall.
REQ-032 SHALL cover simultaneous dmiss=1, ex_br_taken=1 for 2 cycles -> dmiss response both cycles, stall_cnt=2; branch flush appears in cycle 3 when dmiss drops.
REQ-033 SHALL cover branch plus load-use same cycle -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-034 SHALL cover id_halt=1 one cycle, no other events -> halted=1 exactly DRAIN_CYC+1 edges later, all enables 0 thereafter.
REQ-035 SHALL cover id_halt then ex_br_taken in the next cycle -> state RUN, halted stays 0, pc_en=1.
REQ-036 SHALL cover stall_cnt preset near saturation via 65540 imiss cycles -> stall_cnt=16'hFFFF, no wrap; rst pulse mid-stall -> stall_cnt=0 asynchronously.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: prioritised per-cycle event resolution,
// HLT drain sequencing and a saturating stall counter.
module pipeline_ctrl #(
  parameter int unsigned REG_W     = 4,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_br_taken,
  input  logic             imiss,
  input  logic             dmiss,
  input  logic             id_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [15:0]      stall_cnt
);

  localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] drain_cnt_nxt;

  logic load_use;
  logic ev_dmiss;
  logic ev_br;
  logic ev_lu;
  logic ev_imiss;
  logic ev_halt;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  always_comb begin
    load_use = ex_memread && (ex_rd != '0) &&
               ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  end

  // One-hot view of the single winning event for this cycle.
  always_comb begin
    ev_dmiss = dmiss;
    ev_br    = !dmiss && ex_br_taken;
    ev_lu    = !dmiss && !ex_br_taken && load_use;
    ev_imiss = !dmiss && !ex_br_taken && !load_use && imiss;
    ev_halt  = !dmiss && !ex_br_taken && !load_use && !imiss && id_halt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (ev_halt) begin
          state_nxt     = (DRAIN_CYC == 0) ? HALTED : DRAIN;
          drain_cnt_nxt = CNT_W'(DRAIN_CYC);
        end
      end
      DRAIN: begin
        if (ev_br) begin
          state_nxt     = RUN;
          drain_cnt_nxt = '0;
        end else if (!dmiss) begin
          drain_cnt_nxt = drain_cnt - CNT_W'(1);
          if (drain_cnt == CNT_W'(1)) begin
            state_nxt = HALTED;
          end
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt     = RUN;
        drain_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    halted      = (state == HALTED);
    if (!rst && (state != HALTED)) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (ev_dmiss) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end else if (ev_br) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (ev_lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (ev_imiss) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end else if (ev_halt) begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
      end
      // While draining, fetch stays frozen unless a taken branch kills the HLT.
      if ((state == DRAIN) && !ev_br) begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (state != HALTED) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: constant vector table, directed
// multi-cycle sequences and randomized cycles against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned REG_W     = 4;
  localparam int unsigned DRAIN_CYC = 3;

  localparam logic [7:0] R_NONE  = 8'b11111_000;
  localparam logic [7:0] R_DMISS = 8'b00001_001;
  localparam logic [7:0] R_BR    = 8'b11111_110;
  localparam logic [7:0] R_LU    = 8'b00111_010;
  localparam logic [7:0] R_IMISS = 8'b01111_100;
  localparam logic [7:0] R_HALT  = 8'b00111_000;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             ex_br_taken;
  logic             imiss;
  logic             dmiss;
  logic             id_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_flush;
  logic             halted;
  logic [15:0]      stall_cnt;
  logic [7:0]       outs;

  int total;
  int bad;

  pipeline_ctrl #(
    .REG_W    (REG_W),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .ex_br_taken(ex_br_taken),
    .imiss      (imiss),
    .dmiss      (dmiss),
    .id_halt    (id_halt),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .idex_en    (idex_en),
    .exmem_en   (exmem_en),
    .memwb_en   (memwb_en),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .memwb_flush(memwb_flush),
    .halted     (halted),
    .stall_cnt  (stall_cnt)
  );

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, memwb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             mr;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             urs;
    logic             urt;
    logic             br;
    logic             dm;
    logic             im;
    logic             hl;
    logic [7:0]       exp;
  } vec_t;

  vec_t vecs[14];

  // Behavioural model state
  bit m_draining;
  int m_left;
  bit m_halted;
  int m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string n, input logic mr, input int rd, input int rs,
                              input int rt, input logic urs, input logic urt, input logic br,
                              input logic dm, input logic im, input logic hl,
                              input logic [7:0] e);
    vec_t v;
    v.name = n; v.mr = mr; v.rd = REG_W'(rd); v.rs = REG_W'(rs); v.rt = REG_W'(rt);
    v.urs = urs; v.urt = urt; v.br = br; v.dm = dm; v.im = im; v.hl = hl; v.exp = e;
    return v;
  endfunction

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_memread = 1'b0; ex_rd = '0; ex_br_taken = 1'b0;
    imiss = 1'b0; dmiss = 1'b0; id_halt = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #2;
    rst = 1'b0;
    #1;
  endtask

  // Which event wins this cycle: 0 none, 1 dmiss, 2 branch, 3 load-use, 4 imiss, 5 halt
  function automatic int pick_event();
    bit hazard;
    hazard = ex_memread && (ex_rd != 0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (dmiss) return 1;
    if (ex_br_taken) return 2;
    if (hazard) return 3;
    if (imiss) return 4;
    if (id_halt) return 5;
    return 0;
  endfunction

  function automatic logic [7:0] model_out();
    logic [7:0] r;
    int ev;
    if (rst || m_halted) return 8'h00;
    ev = pick_event();
    case (ev)
      1: r = R_DMISS;
      2: r = R_BR;
      3: r = R_LU;
      4: r = R_IMISS;
      5: r = R_HALT;
      default: r = R_NONE;
    endcase
    if (m_draining && ev != 2) r[7:6] = 2'b00;
    return r;
  endfunction

  task automatic model_reset();
    m_draining = 0; m_left = 0; m_halted = 0; m_stall = 0;
  endtask

  task automatic model_step(input logic [7:0] exp);
    int ev;
    if (m_halted) return;
    ev = pick_event();
    if (!exp[7] && m_stall < 65535) m_stall++;
    if (m_draining) begin
      if (ev == 1) begin
      end else if (ev == 2) begin
        m_draining = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_draining = 0;
          m_halted   = 1;
        end
      end
    end else if (ev == 5) begin
      m_draining = 1;
      m_left     = DRAIN_CYC;
    end
  endtask

  initial begin
    logic [7:0] exp;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    imiss = 1'b1;
    model_reset();

    vecs[0]  = mk("no_event",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R_NONE);
    vecs[1]  = mk("lu_rs",        1, 3, 3, 0, 1, 0, 0, 0, 0, 0, R_LU);
    vecs[2]  = mk("lu_reg0",      1, 0, 0, 0, 1, 1, 0, 0, 0, 0, R_NONE);
    vecs[3]  = mk("lu_rt",        1, 5, 2, 5, 0, 1, 0, 0, 0, 0, R_LU);
    vecs[4]  = mk("lu_rs_unused", 1, 3, 3, 0, 0, 1, 0, 0, 0, 0, R_NONE);
    vecs[5]  = mk("lu_no_load",   0, 3, 3, 3, 1, 1, 0, 0, 0, 0, R_NONE);
    vecs[6]  = mk("branch",       0, 0, 0, 0, 0, 0, 1, 0, 0, 0, R_BR);
    vecs[7]  = mk("branch_lu",    1, 7, 7, 0, 1, 0, 1, 0, 0, 0, R_BR);
    vecs[8]  = mk("dmiss",        0, 0, 0, 0, 0, 0, 0, 1, 0, 0, R_DMISS);
    vecs[9]  = mk("dmiss_all",    1, 2, 2, 2, 1, 1, 1, 1, 1, 1, R_DMISS);
    vecs[10] = mk("imiss",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, R_IMISS);
    vecs[11] = mk("lu_imiss",     1, 9, 0, 9, 0, 1, 0, 0, 1, 0, R_LU);
    vecs[12] = mk("imiss_halt",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, R_IMISS);
    vecs[13] = mk("halt",         0, 0, 0, 0, 0, 0, 0, 0, 0, 1, R_HALT);

    // Reset holds everything quiet even with an event pending
    #3;
    check("rst_outs", 32'(outs), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_stall", 32'(stall_cnt), 32'h0);

    for (int i = 0; i < 14; i++) begin
      do_reset();
      ex_memread = vecs[i].mr; ex_rd = vecs[i].rd; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_use_rs = vecs[i].urs; id_use_rt = vecs[i].urt; ex_br_taken = vecs[i].br;
      dmiss = vecs[i].dm; imiss = vecs[i].im; id_halt = vecs[i].hl;
      #1;
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
    end

    // dmiss + branch together for two cycles, then dmiss drops
    do_reset();
    dmiss = 1'b1; ex_br_taken = 1'b1;
    #1;
    check("dm_br_c1", 32'(outs), 32'(R_DMISS));
    tick();
    check("dm_br_c2", 32'(outs), 32'(R_DMISS));
    tick();
    check("dm_br_stall", 32'(stall_cnt), 32'd2);
    dmiss = 1'b0;
    #1;
    check("dm_br_c3", 32'(outs), 32'(R_BR));

    // Single-cycle HLT drains into HALTED after DRAIN_CYC+1 edges
    do_reset();
    id_halt = 1'b1;
    #1;
    check("halt_c0", 32'(outs), 32'(R_HALT));
    tick();
    id_halt = 1'b0;
    #1;
    check("halt_drain_outs", 32'(outs), 32'(R_HALT));
    check("halt_e1", 32'(halted), 32'h0);
    for (int e = 2; e <= DRAIN_CYC + 1; e++) begin
      tick();
      check($sformatf("halt_e%0d", e), 32'(halted), (e == DRAIN_CYC + 1) ? 32'h1 : 32'h0);
    end
    imiss = 1'b1; ex_br_taken = 1'b1;
    #1;
    check("halted_outs", 32'(outs), 32'h0);
    tick();
    check("halted_stay", 32'(halted), 32'h1);
    check("halted_stall", 32'(stall_cnt), 32'(DRAIN_CYC + 1));

    // Branch in the cycle after HLT kills the drain
    do_reset();
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0; ex_br_taken = 1'b1;
    #1;
    check("halt_br_outs", 32'(outs), 32'(R_BR));
    tick();
    ex_br_taken = 1'b0;
    #1;
    check("halt_br_run", 32'(outs), 32'(R_NONE));
    for (int e = 0; e < DRAIN_CYC + 2; e++) tick();
    check("halt_br_nohalt", 32'(halted), 32'h0);

    // Reset mid-drain leaves no history
    do_reset();
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0;
    tick();
    do_reset();
    check("drain_rst_outs", 32'(outs), 32'(R_NONE));
    for (int e = 0; e < DRAIN_CYC + 2; e++) tick();
    check("drain_rst_nohalt", 32'(halted), 32'h0);
    check("drain_rst_stall", 32'(stall_cnt), 32'h0);

    // Randomized cycles against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 99) == 0);
      dmiss       = ($urandom_range(0, 7) == 0);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      imiss       = ($urandom_range(0, 5) == 0);
      ex_memread  = ($urandom_range(0, 2) == 0);
      ex_rd       = REG_W'($urandom_range(0, 3));
      id_rs       = REG_W'($urandom_range(0, 3));
      id_rt       = REG_W'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      id_halt     = ($urandom_range(0, 24) == 0);
      if (rst) model_reset();
      #1;
      exp = model_out();
      check("rand_outs", 32'(outs), 32'(exp));
      check("rand_halted", 32'(halted), 32'(m_halted));
      check("rand_stall", 32'(stall_cnt), 32'(m_stall));
      @(posedge clk);
      if (!rst) model_step(exp);
    end

    // Stall counter saturation, then asynchronous clear mid-stall
    do_reset();
    imiss = 1'b1;
    for (int e = 0; e < 65540; e++) @(posedge clk);
    #1;
    check("stall_sat", 32'(stall_cnt), 32'hFFFF);
    check("stall_sat_outs", 32'(outs), 32'(R_IMISS));
    #2;
    rst = 1'b1;
    #1;
    check("stall_async_clr", 32'(stall_cnt), 32'h0);
    check("stall_rst_outs", 32'(outs), 32'h0);
    rst = 1'b0;
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
